// File: rtl/ram_if.sv
// ram_if - processor <-> data-memory request/response bundle.
//   master : processor side (drives request, receives data/ready/busy)
//   slave  : memory side    (ram_responder)
// Signals:
//   ram_enable          request strobe
//   ram_read_write      1 = write, 0 = read
//   ram_address         word address (AW bits)
//   ram_data_write_out  write data (DATA_WIDTH bits)
//   ram_data_read_in    registered read data
//   ram_ready           one-cycle completion pulse
//   ram_busy            request in flight / initialising
interface ram_if #(
  parameter int AW         = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  ram_enable;
  logic                  ram_read_write;
  logic [AW-1:0]         ram_address;
  logic [DATA_WIDTH-1:0] ram_data_write_out;
  logic [DATA_WIDTH-1:0] ram_data_read_in;
  logic                  ram_ready;
  logic                  ram_busy;

  modport master (
    output ram_enable, ram_read_write, ram_address, ram_data_write_out,
    input  ram_data_read_in, ram_ready, ram_busy
  );

  modport slave (
    input  ram_enable, ram_read_write, ram_address, ram_data_write_out,
    output ram_data_read_in, ram_ready, ram_busy
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder - slow data-memory model serving the processor RAM port.
// A request seen in IDLE is captured, held for WAIT_STATES cycles, then
// completed with a one-cycle ram_ready pulse. Reads update
// ram_data_read_in on the edge entering RESPOND; writes commit on that
// same edge.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    ram_if.slave (enable/rw/address/wdata in; rdata/ready/busy out)
// Optional build macro:
//   RAM_INIT_ZERO_EN - after reset, sweep zeros into every word (one per
//   cycle, ram_busy high for NUM_RAM_ADDRESS cycles) before accepting
//   requests. Without it the array is never cleared.
module ram_responder #(
  parameter int NUM_RAM_ADDRESS = 256,
  parameter int DATA_WIDTH      = 32,
  parameter int WAIT_STATES     = 2
) (
  input logic   clk,
  input logic   reset,
  ram_if.slave  bus
);
  localparam int            AW    = (NUM_RAM_ADDRESS > 1) ? $clog2(NUM_RAM_ADDRESS) : 1;
  localparam logic [3:0]    WS    = 4'(WAIT_STATES);
  localparam logic [AW:0]   DEPTH = (AW+1)'(NUM_RAM_ADDRESS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
`ifdef RAM_INIT_ZERO_EN
    , INIT  = 2'd3
`endif
  } state_t;

`ifdef RAM_INIT_ZERO_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  req_we;
  logic [AW-1:0]         req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  ready_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] rdata_q;
`ifdef RAM_INIT_ZERO_EN
  logic [AW:0]           init_cnt;
`endif

  logic [DATA_WIDTH-1:0] mem [NUM_RAM_ADDRESS];

  // Operation performed on the edge that enters RESPOND. With zero wait
  // states that edge is the accept edge itself, so the live inputs are
  // used instead of the (not yet loaded) request registers.
  logic                  accept;
  logic                  commit;
  logic                  op_we;
  logic [AW-1:0]         op_addr;
  logic [DATA_WIDTH-1:0] op_data;
  logic                  op_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    accept      = (state == IDLE) && bus.ram_enable;
    op_we       = accept ? bus.ram_read_write     : req_we;
    op_addr     = accept ? bus.ram_address        : req_addr;
    op_data     = accept ? bus.ram_data_write_out : req_data;
    commit      = (accept && (WS == 4'd0)) || ((state == WAIT) && (wait_cnt == 4'd1));
    op_in_range = {1'b0, op_addr} < DEPTH;
    rd_word     = op_in_range ? mem[op_addr] : '0;
  end

  // Memory write port. Gated by reset so an edge seen while reset is
  // held can never commit a pending write.
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = reset && commit && op_we && op_in_range;
    mem_waddr = op_addr;
    mem_wdata = op_data;
`ifdef RAM_INIT_ZERO_EN
    if ((state == INIT) && (init_cnt < DEPTH)) begin
      mem_we    = reset;
      mem_waddr = init_cnt[AW-1:0];
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RST_STATE;
      wait_cnt <= '0;
      req_we   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
`ifdef RAM_INIT_ZERO_EN
      init_cnt <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      if (commit && !op_we) rdata_q <= rd_word;
      unique case (state)
        IDLE: begin
          if (bus.ram_enable) begin
            req_we   <= bus.ram_read_write;
            req_addr <= bus.ram_address;
            req_data <= bus.ram_data_write_out;
            wait_cnt <= WS;
            if (WS == 4'd0) begin
              state   <= RESPOND;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state  <= WAIT;
              busy_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state   <= RESPOND;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        RESPOND: state <= IDLE;
`ifdef RAM_INIT_ZERO_EN
        // busy rises on the first sweep edge and falls one edge after the
        // last word is written, giving exactly NUM_RAM_ADDRESS busy cycles.
        INIT: begin
          if (init_cnt == DEPTH) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
            busy_q   <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_data_read_in = rdata_q;
  assign bus.ram_ready        = ready_q;
  assign bus.ram_busy         = busy_q;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder - two responders (2 wait states and 0 wait states)
// driven by directed and random requests; a transaction-level model per
// instance predicts ready/busy/read data every cycle.
module tb_ram_responder;
  localparam int WS0 = 2;
  localparam int WS1 = 0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       en = '0;
  logic [1:0]       rw = '0;
  logic [1:0][7:0]  ad = '0;
  logic [1:0][31:0] wdat = '0;
  logic [1:0]       rdy;
  logic [1:0]       bsy;
  logic [1:0][31:0] rdat;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int WS = (g == 0) ? WS0 : WS1;

    ram_if #(.AW(8), .DATA_WIDTH(32)) bus ();
    assign bus.ram_enable         = en[g];
    assign bus.ram_read_write     = rw[g];
    assign bus.ram_address        = ad[g];
    assign bus.ram_data_write_out = wdat[g];
    assign rdy[g]  = bus.ram_ready;
    assign bsy[g]  = bus.ram_busy;
    assign rdat[g] = bus.ram_data_read_in;

    ram_responder #(
      .NUM_RAM_ADDRESS(256), .DATA_WIDTH(32), .WAIT_STATES(WS)
    ) dut (
      .clk(clk), .reset(reset), .bus(bus)
    );

    // Transaction model: a request accepted at edge e completes at edge
    // e+WS; the next request can be accepted from edge e+WS+2 on.
    int          ecnt = 0;
    int          next_free = 0;
    int          c_edge = 0;
    bit          pend = 1'b0;
    bit          p_we;
    logic [7:0]  p_a;
    logic [31:0] p_d;
    logic        m_rdy = 1'b0;
    logic        m_busy = 1'b0;
    logic [31:0] m_rd = '0;
    logic [31:0] mm [256];

    always @(posedge clk) begin
      if (!reset) begin
        pend = 1'b0; m_rdy = 1'b0; m_busy = 1'b0; m_rd = '0; next_free = 0;
      end else begin
        if (!pend && ecnt >= next_free && en[g]) begin
          pend = 1'b1; p_we = rw[g]; p_a = ad[g]; p_d = wdat[g];
          c_edge = ecnt + WS; next_free = ecnt + WS + 2;
        end
        m_rdy = 1'b0;
        if (pend && ecnt == c_edge) begin
          m_rdy = 1'b1; pend = 1'b0;
          if (p_we) mm[p_a] = p_d;
          else      m_rd = mm[p_a];
        end
        m_busy = pend;
      end
      ecnt++;
    end

    always @(negedge clk) begin
      chk($sformatf("ready_d%0d", g), 32'(bus.ram_ready), 32'(m_rdy));
      chk($sformatf("busy_d%0d", g),  32'(bus.ram_busy),  32'(m_busy));
      chk($sformatf("rdata_d%0d", g), bus.ram_data_read_in, m_rd);
    end
  end

  // One access with a clean handshake; enable drops in the ready cycle.
  task automatic do_req(input int d, input bit we, input logic [7:0] a,
                        input logic [31:0] wd, input bit mid,
                        input logic [7:0] ma, input logic [31:0] md,
                        output logic [31:0] rd);
    int lat, bn, ws;
    ws = (d == 0) ? WS0 : WS1;
    @(negedge clk); #1;
    en[d] = 1'b1; rw[d] = we; ad[d] = a; wdat[d] = wd;
    lat = 0; bn = 0;
    forever begin
      @(negedge clk); lat++;
      if (bsy[d]) bn++;
      if (rdy[d] || lat > 40) break;
      if (mid && lat == 1) begin #1; ad[d] = ma; wdat[d] = md; end
    end
    rd = rdat[d];
    #1; en[d] = 1'b0;
    chk($sformatf("latency_d%0d", d), 32'(lat), 32'(ws + 1));
    chk($sformatf("busy_cycles_d%0d", d), 32'(bn), 32'(ws));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int pulses, first, last;
    bit we;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_rdata", rdat[0], 32'h0);
    chk("rst_ready", 32'(rdy[0]), 32'h0);
    chk("rst_busy",  32'(bsy[0]), 32'h0);

    // Write then read back, read data held across writes
    do_req(0, 1'b1, 8'd3, 32'h0000001C, 1'b0, 8'd0, 32'h0, rd);
    chk("write_keeps_rdata", rd, 32'h0);
    do_req(0, 1'b0, 8'd3, 32'h0, 1'b0, 8'd0, 32'h0, rd);
    chk("read3", rd, 32'h0000001C);
    do_req(0, 1'b1, 8'd5, 32'h00000055, 1'b0, 8'd0, 32'h0, rd);
    chk("rdata_hold_after_w5", rd, 32'h0000001C);

    // Mid-request address/data change is ignored
    do_req(0, 1'b1, 8'd7, 32'h00000077, 1'b0, 8'd0, 32'h0, rd);
    do_req(0, 1'b1, 8'd3, 32'hA5A5A5A5, 1'b1, 8'd7, 32'hDEADBABE, rd);
    do_req(0, 1'b0, 8'd7, 32'h0, 1'b0, 8'd0, 32'h0, rd);
    chk("addr7_untouched", rd, 32'h00000077);
    do_req(0, 1'b0, 8'd3, 32'h0, 1'b0, 8'd0, 32'h0, rd);
    chk("addr3_captured", rd, 32'hA5A5A5A5);

    // Reset during WAIT of a write
    do_req(0, 1'b1, 8'd9, 32'h00009999, 1'b0, 8'd0, 32'h0, rd);
    @(negedge clk); #1;
    en[0] = 1'b1; rw[0] = 1'b1; ad[0] = 8'd9; wdat[0] = 32'h12345678;
    @(negedge clk);
    chk("rst_test_wait_busy", 32'(bsy[0]), 32'h1);
    #1 en[0] = 1'b0;
    @(negedge clk); #1 reset = 1'b0;
    pulses = 0;
    repeat (3) begin @(negedge clk); if (rdy[0]) pulses++; end
    chk("rst_during_reset_busy", 32'(bsy[0]), 32'h0);
    #1 reset = 1'b1;
    repeat (3) begin @(negedge clk); if (rdy[0]) pulses++; end
    chk("rst_no_ready", 32'(pulses), 32'h0);
    do_req(0, 1'b0, 8'd9, 32'h0, 1'b0, 8'd0, 32'h0, rd);
    chk("addr9_prior_value", rd, 32'h00009999);

    // Back-to-back with enable held, zero wait states
    @(negedge clk); #1;
    en[1] = 1'b1; rw[1] = 1'b1; ad[1] = 8'd10; wdat[1] = 32'hA0;
    pulses = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rdy[1]) begin
        if (first < 0) first = c;
        last = c;
        pulses++;
        #1;
        if (pulses == 3) en[1] = 1'b0;
        else begin ad[1] = 8'(10 + pulses); wdat[1] = 32'hA0 + 32'(pulses); end
      end
    end
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_first",  32'(first),  32'd0);
    chk("b2b_span",   32'(last - first), 32'd4);
    for (int i = 0; i < 3; i++) begin
      do_req(1, 1'b0, 8'(10 + i), 32'h0, 1'b0, 8'd0, 32'h0, rd);
      chk($sformatf("b2b_read%0d", i), rd, 32'hA0 + 32'(i));
    end

    // Random traffic over a preloaded window on both instances
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 32; a++)
        do_req(d, 1'b1, 8'(a), $urandom, 1'b0, 8'd0, 32'h0, rd);
    for (int t = 0; t < 150; t++) begin
      for (int d = 0; d < 2; d++) begin
        we = 1'($urandom_range(0, 1));
        do_req(d, we, 8'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), 8'($urandom), $urandom, rd);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Data-memory responder that serves the processor's RAM port.
- Accepts read/write requests on ram_enable, ram_read_write, ram_address and ram_data_write_out.
- Returns read data on ram_data_read_in, with a one-cycle completion pulse after a configurable number of wait states.
- Sits beside the processor in the top level as the far end of its RAM interface, and gives the processor side a slow-memory model with a defined completion handshake.

Parameters:
- NUM_RAM_ADDRESS, 256, number of 32-bit words; address width AW = $clog2(NUM_RAM_ADDRESS).
- DATA_WIDTH, 32, word width.
- WAIT_STATES, 2, cycles between request acceptance and completion; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0); single clock domain.
- ram_enable  input  1  request strobe from processor.
- ram_read_write  input  1  1 = write, 0 = read.
- ram_address  input  AW  word address.
- ram_data_write_out  input  DATA_WIDTH  write data from processor.
- ram_data_read_in  output  DATA_WIDTH  registered read data to processor.
- ram_ready  output  1  one-cycle completion pulse (read or write).
- ram_busy  output  1  high while a request is in flight or while initialising.

Behaviour:
- Reset values: ram_data_read_in = 0, ram_ready = 0, ram_busy = 0, FSM = IDLE, wait counter = 0.
- The memory array is not reset unless RAM_INIT_ZERO_EN is defined.
- States: IDLE, WAIT, RESPOND (plus INIT under RAM_INIT_ZERO_EN).
- IDLE:
  - If ram_enable = 1 at a rising edge, capture address, ram_read_write and write data into request registers.
  - Load the counter with WAIT_STATES and set ram_busy = 1.
  - Go to WAIT if WAIT_STATES > 0, else go to RESPOND.
- WAIT: decrement the counter each cycle; when it reaches 1, go to RESPOND.
- RESPOND (exactly one cycle):
  - ram_ready = 1 and ram_busy = 0 in this cycle.
  - Write: memory[captured address] <= captured data at the edge entering RESPOND.
  - Read: ram_data_read_in is updated at the edge entering RESPOND and is valid while ram_ready = 1.
  - Next state is IDLE.
- Latency: request sampled at edge N, so ram_ready is high during cycle N+1+WAIT_STATES (WAIT_STATES = 0 gives ready in cycle N+1).
- ram_data_read_in holds its value until the next read completes; write completions do not change it.
- Inputs are ignored outside IDLE:
  - Changes to address or data mid-request have no effect; the captured values are used.
  - If ram_enable is still 1 in the IDLE cycle after RESPOND, a new request is accepted. The processor therefore deasserts ram_enable in the ram_ready cycle to issue exactly one access.
- Read-after-write to the same address: the read returns the new data (the write commits before the next request is accepted).
- Out-of-range address (only possible when NUM_RAM_ADDRESS is not a power of 2):
  - Reads return 0.
  - Writes are dropped.
  - ram_ready still pulses with normal latency.
- Reset mid-request: the FSM returns to IDLE immediately, the pending write is discarded (memory unchanged), and no ram_ready pulse is generated.
- ram_ready and ram_busy are never high in the same cycle.

Optional Feature:
- Macro RAM_INIT_ZERO_EN.
- Defined:
  - After reset deasserts, the FSM enters INIT and writes 0 to addresses 0..NUM_RAM_ADDRESS-1, one per cycle.
  - ram_busy = 1 for exactly NUM_RAM_ADDRESS cycles; ram_enable is ignored during INIT.
  - Then go to IDLE with no ram_ready pulse.
  - Reset during INIT restarts the sweep from address 0.
- Undefined: no INIT state, memory contents are X until written, and the FSM enters IDLE directly after reset.

Test Plan:
- Reset low for 2 cycles, then release → ram_data_read_in = 0, ram_ready = 0, ram_busy = 0. With RAM_INIT_ZERO_EN, ram_busy stays high for 256 cycles, then drops to 0.
- Write 28 (0x0000001C) to address 3 with WAIT_STATES = 2 → ram_busy high for 2 cycles; ram_ready pulses in cycle N+3; ram_data_read_in stays unchanged.
- Read address 3 after that write → ram_ready in cycle N+3 with ram_data_read_in = 0x0000001C; the value is held through later writes to address 5.
- Change ram_address from 3 to 7 and ram_data_write_out to 0xDEADBABE while WAIT → the access uses the captured values; address 7 is untouched (read back 0 under RAM_INIT_ZERO_EN).
- ram_enable held high for 3 consecutive requests with WAIT_STATES = 0 → ram_ready pulses every 2nd cycle; each request is completed exactly once.
- Assert reset during WAIT of a write of 0x12345678 to address 9 → no ram_ready pulse; a later read of address 9 returns its prior value; the FSM is in IDLE.
